// File: rtl/mul_seq_ctrl_if.sv
// Request/response handshake bundle for mul_seq_ctrl.
// The master issues operands and takes results; the slave is the sequencer.
interface mul_seq_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_hi;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;

    modport master (
        output req_valid, req_a, req_b, req_hi, rsp_ready,
        input  req_ready, rsp_valid, rsp_lo, rsp_hi
    );

    modport slave (
        input  req_valid, req_a, req_b, req_hi, rsp_ready,
        output req_ready, rsp_valid, rsp_lo, rsp_hi
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequencer driving an external three-cell 16x16 partial-product multiplier.
// Define MUL_SEQ_CTRL_HI_EN to add the hi*hi pass that completes the 64-bit product.
module mul_seq_ctrl #(
    parameter int unsigned CELL_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mul_seq_ctrl_if.slave        bus,
    output logic                 busy,
    output logic [31:0]          mul_src1,
    output logic [31:0]          mul_src2,
    output logic                 mul_en,
    input  logic [31:0]          mul_p1,
    input  logic [31:0]          mul_p2,
    input  logic [31:0]          mul_p3
);

    localparam logic [1:0] CntInit = 2'(CELL_LATENCY - 1);

`ifdef MUL_SEQ_CTRL_HI_EN
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StIssueLo = 3'd1,
        StCapLo   = 3'd2,
        StIssueHi = 3'd3,
        StCapHi   = 3'd4,
        StDone    = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StIssueLo = 3'd1,
        StCapLo   = 3'd2,
        StDone    = 3'd5
    } state_e;
`endif

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_lo_q;
    logic [31:0] rsp_hi_q;
    logic        busy_q;
    logic [31:0] mul_src1_q;
    logic [31:0] mul_src2_q;
    logic        mul_en_q;

    // Cross terms are summed at 33 bits so their carry survives the shift.
    logic [32:0] mid_sum;
    logic [63:0] lo64_calc;

    always_comb begin
        mid_sum   = {1'b0, mul_p2} + {1'b0, mul_p3};
        lo64_calc = {32'h0, mul_p1} + ({31'h0, mid_sum} << 16);
    end

`ifdef MUL_SEQ_CTRL_HI_EN
    logic [15:0] a_hi_q;
    logic [15:0] b_hi_q;
    logic        hi_q;
    logic [63:0] lo64_q;
    logic [63:0] full_calc;

    assign full_calc = lo64_q + {mul_p1, 32'h0};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= 2'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_lo_q    <= 32'h0;
            rsp_hi_q    <= 32'h0;
            busy_q      <= 1'b0;
            mul_src1_q  <= 32'h0;
            mul_src2_q  <= 32'h0;
            mul_en_q    <= 1'b0;
`ifdef MUL_SEQ_CTRL_HI_EN
            a_hi_q      <= 16'h0;
            b_hi_q      <= 16'h0;
            hi_q        <= 1'b0;
            lo64_q      <= 64'h0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        cnt_q       <= CntInit;
                        mul_src1_q  <= bus.req_a;
                        mul_src2_q  <= bus.req_b;
                        mul_en_q    <= 1'b1;
`ifdef MUL_SEQ_CTRL_HI_EN
                        a_hi_q      <= bus.req_a[31:16];
                        b_hi_q      <= bus.req_b[31:16];
                        hi_q        <= bus.req_hi;
`endif
                        state_q     <= StIssueLo;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                StIssueLo: begin
                    if (cnt_q == 2'd0) begin
                        mul_en_q   <= 1'b0;
                        mul_src1_q <= 32'h0;
                        mul_src2_q <= 32'h0;
                        state_q    <= StCapLo;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                StCapLo: begin
`ifdef MUL_SEQ_CTRL_HI_EN
                    lo64_q <= lo64_calc;
                    if (hi_q) begin
                        cnt_q      <= CntInit;
                        mul_src1_q <= {16'h0, a_hi_q};
                        mul_src2_q <= {16'h0, b_hi_q};
                        mul_en_q   <= 1'b1;
                        state_q    <= StIssueHi;
                    end else begin
                        rsp_lo_q    <= lo64_calc[31:0];
                        rsp_hi_q    <= lo64_calc[63:32];
                        rsp_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
`else
                    rsp_lo_q    <= lo64_calc[31:0];
                    rsp_hi_q    <= lo64_calc[63:32];
                    rsp_valid_q <= 1'b1;
                    state_q     <= StDone;
`endif
                end
`ifdef MUL_SEQ_CTRL_HI_EN
                StIssueHi: begin
                    if (cnt_q == 2'd0) begin
                        mul_en_q   <= 1'b0;
                        mul_src1_q <= 32'h0;
                        mul_src2_q <= 32'h0;
                        state_q    <= StCapHi;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                StCapHi: begin
                    rsp_lo_q    <= full_calc[31:0];
                    rsp_hi_q    <= full_calc[63:32];
                    rsp_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
`endif
                StDone: begin
                    // Result registers are left holding the last response.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_lo    = rsp_lo_q;
    assign bus.rsp_hi    = rsp_hi_q;
    assign busy          = busy_q;
    assign mul_src1      = mul_src1_q;
    assign mul_src2      = mul_src2_q;
    assign mul_en        = mul_en_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: one instance at CELL_LATENCY=1, one at 3,
// each driving a registered cell model that only produces results after the latency.
module tb_mul_seq_ctrl;

`ifdef MUL_SEQ_CTRL_HI_EN
    localparam bit HiEn = 1'b1;
`else
    localparam bit HiEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_a = 32'h0;
    logic [31:0] req_b = 32'h0;
    logic        req_hi = 1'b0;
    logic        rsp_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl_if if0 ();
    mul_seq_ctrl_if if3 ();

    assign if0.req_valid = req_valid && !sel;
    assign if3.req_valid = req_valid && sel;
    assign if0.req_a     = req_a;
    assign if3.req_a     = req_a;
    assign if0.req_b     = req_b;
    assign if3.req_b     = req_b;
    assign if0.req_hi    = req_hi;
    assign if3.req_hi    = req_hi;
    assign if0.rsp_ready = rsp_ready && !sel;
    assign if3.rsp_ready = rsp_ready && sel;

    logic        busy0, en0, busy3, en3;
    logic [31:0] s1_0, s2_0, s1_3, s2_3;
    logic [31:0] p1_0 = 32'h0, p2_0 = 32'h0, p3_0 = 32'h0;
    logic [31:0] p1_3 = 32'h0, p2_3 = 32'h0, p3_3 = 32'h0;
    int          ecnt0 = 0, ecnt3 = 0;

    mul_seq_ctrl #(.CELL_LATENCY(1)) u_dut1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (if0),
        .busy     (busy0),
        .mul_src1 (s1_0),
        .mul_src2 (s2_0),
        .mul_en   (en0),
        .mul_p1   (p1_0),
        .mul_p2   (p2_0),
        .mul_p3   (p3_0)
    );

    mul_seq_ctrl #(.CELL_LATENCY(3)) u_dut3 (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (if3),
        .busy     (busy3),
        .mul_src1 (s1_3),
        .mul_src2 (s2_3),
        .mul_en   (en3),
        .mul_p1   (p1_3),
        .mul_p2   (p2_3),
        .mul_p3   (p3_3)
    );

    // Cell models: results appear only on the CELL_LATENCY-th consecutive enabled edge.
    always @(posedge clk) begin
        if (en0) begin
            if (ecnt0 == 0) begin
                p1_0 <= {16'h0, s1_0[15:0]} * {16'h0, s2_0[15:0]};
                p2_0 <= {16'h0, s1_0[15:0]} * {16'h0, s2_0[31:16]};
                p3_0 <= {16'h0, s1_0[31:16]} * {16'h0, s2_0[15:0]};
            end else begin
                {p1_0, p2_0, p3_0} <= {3{32'hDEADBEEF}};
            end
            ecnt0 <= ecnt0 + 1;
        end else begin
            ecnt0 <= 0;
        end
        if (en3) begin
            if (ecnt3 == 2) begin
                p1_3 <= {16'h0, s1_3[15:0]} * {16'h0, s2_3[15:0]};
                p2_3 <= {16'h0, s1_3[15:0]} * {16'h0, s2_3[31:16]};
                p3_3 <= {16'h0, s1_3[31:16]} * {16'h0, s2_3[15:0]};
            end else begin
                {p1_3, p2_3, p3_3} <= {3{32'hDEADBEEF}};
            end
            ecnt3 <= ecnt3 + 1;
        end else begin
            ecnt3 <= 0;
        end
    end

    logic        o_req_ready, o_rsp_valid, o_busy, o_en;
    logic [31:0] o_rsp_lo, o_rsp_hi, o_s1, o_s2;

    assign o_req_ready = sel ? if3.req_ready : if0.req_ready;
    assign o_rsp_valid = sel ? if3.rsp_valid : if0.rsp_valid;
    assign o_rsp_lo    = sel ? if3.rsp_lo : if0.rsp_lo;
    assign o_rsp_hi    = sel ? if3.rsp_hi : if0.rsp_hi;
    assign o_busy      = sel ? busy3 : busy0;
    assign o_en        = sel ? en3 : en0;
    assign o_s1        = sel ? s1_3 : s1_0;
    assign o_s2        = sel ? s2_3 : s2_0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(o_req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'd0);
        chk({tag, "_rsp"}, {o_rsp_hi, o_rsp_lo}, 64'd0);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_mul_en"}, 64'(o_en), 64'd0);
        chk({tag, "_mul_src"}, {o_s1, o_s2}, 64'd0);
    endtask

    // Issue one request, wait for DONE, check latency/result, then complete it.
    task automatic do_req(input string tag, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input bit hi, input int lat_exp,
                          input int en_exp, input logic [31:0] lo_exp,
                          input logic [31:0] hi_exp, input bit finish);
        int k;
        int en_cnt;
        sel    = s;
        req_a  = a;
        req_b  = b;
        req_hi = hi;
        chk({tag, "_ready_pre"}, 64'(o_req_ready), 64'd1);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk({tag, "_ready_busy"}, {62'd0, o_req_ready, o_busy}, 64'd1);
        k      = 1;
        en_cnt = 0;
        while (k <= 40 && !o_rsp_valid) begin
            if (o_en) en_cnt++;
            step();
            k++;
        end
        chk({tag, "_latency"}, 64'(k), 64'(lat_exp));
        chk({tag, "_en_cycles"}, 64'(en_cnt), 64'(en_exp));
        chk({tag, "_result"}, {o_rsp_hi, o_rsp_lo}, {hi_exp, lo_exp});
        chk({tag, "_done_cell_idle"}, {o_s1, o_s2, 31'd0, o_en}, 96'd0);
        if (finish) begin
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            chk({tag, "_after"}, {61'd0, o_rsp_valid, o_busy, o_req_ready}, 64'd1);
        end
    endtask

    initial begin
        step();
        step();
        sel = 1'b0;
        chk_all_zero("reset0");
        sel = 1'b1;
        chk_all_zero("reset3");
        reset_n = 1'b1;
        step();
        chk("ready_after_reset0", 64'(if0.req_ready), 64'd1);
        chk("ready_after_reset3", 64'(if3.req_ready), 64'd1);

        do_req("small_hi", 1'b0, 32'h00010002, 32'h00030004, 1'b1,
               HiEn ? 5 : 3, HiEn ? 2 : 1, 32'h000A0008, HiEn ? 32'h3 : 32'h0, 1'b1);
        do_req("ones_hi", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
               HiEn ? 5 : 3, HiEn ? 2 : 1, 32'h00000001,
               HiEn ? 32'hFFFFFFFE : 32'h0001FFFD, 1'b1);
        do_req("ones_nohi", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
               3, 1, 32'h00000001, 32'h0001FFFD, 1'b1);

        // Stall in DONE with a competing request that must be ignored.
        do_req("stall", 1'b0, 32'd3, 32'd5, 1'b0, 3, 1, 32'd15, 32'd0, 1'b0);
        req_a     = 32'h0BAD0BAD;
        req_b     = 32'h00001234;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("stall_hold%0d", i),
                {29'd0, o_rsp_valid, o_req_ready, o_busy, o_rsp_hi, o_rsp_lo},
                {29'd0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd15});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        step();
        chk("stall_no_queue", {62'd0, o_busy, o_rsp_valid}, 64'd0);

        // Reset in the middle of an operation (ISSUE_HI when the hi pass exists).
        sel       = 1'b0;
        req_a     = 32'h11111111;
        req_b     = 32'h00000002;
        req_hi    = 1'b1;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("midop_busy", 64'(o_busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midop_reset");
        #2;
        reset_n = 1'b1;
        step();
        chk("midop_after", {62'd0, o_req_ready, o_rsp_valid}, 64'd2);
        do_req("post_reset", 1'b0, 32'd7, 32'd6, 1'b1,
               HiEn ? 5 : 3, HiEn ? 2 : 1, 32'd42, 32'd0, 1'b1);

        do_req("lat3_hi", 1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b1,
               HiEn ? 9 : 5, HiEn ? 6 : 3, 32'h242D2080,
               HiEn ? 32'h0B00EA4E : 32'h0000441E, 1'b1);
        do_req("lat3_nohi", 1'b1, 32'd7, 32'd6, 1'b0, 5, 3, 32'd42, 32'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
